// File: rtl/uart_tx_arbiter_pkg.sv
// ============================================================================
// Module      : uart_tx_arbiter_pkg
// Description : Shared UART timing constants and arbiter FSM state encoding.
//               uart_tx and uart_tx_arbiter both derive their bit time from
//               these constants, so their baud divisors stay identical.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_tx_arbiter_pkg;

  // Board clock and line rate.
  localparam int CLK_FREQ   = 50_000_000;
  localparam int BAUD_RATE  = 9600;

  // sclk cycles per UART bit.
  localparam int BIT_CYCLES_DEF = CLK_FREQ / BAUD_RATE;

  // Bits per frame: start + 8 data + stop.
  localparam int FRAME_BITS = 10;

  // Arbiter FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin selector. The search starts at the
//               requester after last_i and wraps modulo NUM_REQ. It returns a
//               one-hot winner and an any-request flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int LW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [LW-1:0]      last_i,
  output logic [NUM_REQ-1:0] win_o,
  output logic               any_o
);

  // One bit wider than an index, so that last + offset never overflows.
  logic [LW:0]   sum_d;
  logic [LW-1:0] sel_d;
  logic          found_d;

  // Scan offsets 1..NUM_REQ from last_i and keep the first active requester.
  always_comb begin
    win_o   = '0;
    found_d = 1'b0;
    sum_d   = '0;
    sel_d   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      sum_d = {1'b0, last_i} + (LW+1)'(off);
      if (sum_d >= (LW+1)'(NUM_REQ)) begin
        sum_d = sum_d - (LW+1)'(NUM_REQ);
      end
      sel_d = sum_d[LW-1:0];
      if (!found_d && req_i[sel_d]) begin
        win_o[sel_d] = 1'b1;
        found_d      = 1'b1;
      end
    end
    any_o = found_d;
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter that shares one uart_tx among NUM_REQ
//               byte sources. It grants one requester, pulses tx_trig with
//               the byte held on tx_data, and then blocks new grants for one
//               frame time. uart_tx has no busy flag, so this frame-time
//               block is what keeps a second byte from overlapping the first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int BIT_CYCLES   = BIT_CYCLES_DEF,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                 sclk,
  input  logic                 s_rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 busy,
  output logic                 tx_trig,
  output logic [7:0]           tx_data
);

  localparam int             FRAME_CYCLES = FRAME_BITS * BIT_CYCLES + GUARD_CYCLES;
  localparam int             CW           = $clog2(FRAME_CYCLES);
  localparam int             LW           = $clog2(NUM_REQ);
  localparam logic [CW-1:0]  CNT_LOAD     = CW'(FRAME_CYCLES - 1);
  localparam logic [LW-1:0]  LAST_RST     = LW'(NUM_REQ - 1);

  arb_state_e          state_q;
  logic [CW-1:0]       cnt_q;
  logic [LW-1:0]       last_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic                busy_q;
  logic                tx_trig_q;
  logic [7:0]          tx_data_q;

  logic [NUM_REQ-1:0]  win_d;
  logic                any_d;
  logic [LW-1:0]       idx_d;
  logic [7:0]          byte_d;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req_i  (req),
    .last_i (last_q),
    .win_o  (win_d),
    .any_o  (any_d)
  );

  // Convert the one-hot winner into its index and pick out its byte.
  always_comb begin
    idx_d  = '0;
    byte_d = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_d[i]) begin
        idx_d  = LW'(i);
        byte_d = req_data[8*i +: 8];
      end
    end
  end

  // FSM, frame counter and output registers. WAIT lasts FRAME_CYCLES-1
  // cycles (count FRAME_CYCLES-1 down to 1), so busy stays high for exactly
  // FRAME_CYCLES cycles including ISSUE.
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      last_q    <= LAST_RST;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      tx_trig_q <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_d) begin
            tx_data_q <= byte_d;
            last_q    <= idx_d;
            gnt_q     <= win_d;
            tx_trig_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          tx_trig_q <= 1'b0;
          gnt_q     <= '0;
          cnt_q     <= CNT_LOAD;
          state_q   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_q == CW'(1)) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign tx_trig = tx_trig_q;
  assign tx_data = tx_data_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed self-checking bench for uart_tx_arbiter with
//               BIT_CYCLES=4 and GUARD_CYCLES=2, which gives FRAME_CYCLES=42.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int N       = 4;
  localparam int FRAME   = 42;
  localparam int SPACING = FRAME + 1;

  logic         sclk;
  logic         s_rst;
  logic [N-1:0] req;
  logic [8*N-1:0] req_data;
  logic [N-1:0] gnt;
  logic         busy;
  logic         tx_trig;
  logic [7:0]   tx_data;

  int checks;
  int failures;
  int n;
  int trig_seen;

  uart_tx_arbiter #(
    .NUM_REQ      (N),
    .BIT_CYCLES   (4),
    .GUARD_CYCLES (2)
  ) dut (
    .sclk     (sclk),
    .s_rst    (s_rst),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .busy     (busy),
    .tx_trig  (tx_trig),
    .tx_data  (tx_data)
  );

  // 20 ns clock period.
  initial sclk = 1'b0;
  always #10 sclk = ~sclk;

  // Advance one clock edge, then settle 1 ns before sampling or driving.
  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Step until tx_trig is seen; ncyc is the number of edges taken. The
  // bound is 200 cycles, and running out of it counts as a failed check.
  task automatic wait_trig(input string tag, output int ncyc);
    ncyc = 0;
    do begin
      step();
      ncyc++;
    end while (!tx_trig && ncyc < 200);
    chk({tag, "_trig_seen"}, 32'(tx_trig), 32'd1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    s_rst    = 1'b1;
    req      = 4'hF;
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    // 1: reset held with all requests high
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_gnt",  32'(gnt),     32'h0);
      chk("rst_trig", 32'(tx_trig), 32'h0);
      chk("rst_busy", 32'(busy),    32'h0);
      chk("rst_data", 32'(tx_data), 32'h00);
    end
    req   = 4'h0;
    s_rst = 1'b0;
    step();
    chk("idle_busy", 32'(busy), 32'h0);

    // 2: single requester 2 with byte 55, one cycle latency
    req      = 4'b0100;
    req_data = {8'h00, 8'h55, 8'h00, 8'h00};
    step();
    chk("t2_gnt",  32'(gnt),     32'h4);
    chk("t2_trig", 32'(tx_trig), 32'h1);
    chk("t2_data", 32'(tx_data), 32'h55);
    chk("t2_busy", 32'(busy),    32'h1);
    req = 4'h0;
    n = 1;
    step();
    chk("t2_trig_pulse", 32'(tx_trig), 32'h0);
    chk("t2_gnt_pulse",  32'(gnt),     32'h0);
    while (busy && n < 100) begin
      n++;
      step();
    end
    chk("t2_busy_len", 32'(n), 32'(FRAME));
    chk("t2_data_hold", 32'(tx_data), 32'h55);

    // 3: all requesting after a pointer reset gives grants 0,1,2,3,0 spaced 43
    s_rst = 1'b1;
    step();
    s_rst    = 1'b0;
    req      = 4'hF;
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    step();
    chk("t3_g0", 32'(gnt), 32'h1);
    chk("t3_d0", 32'(tx_data), 32'hA0);
    wait_trig("t3_1", n);
    chk("t3_sp1", 32'(n), 32'(SPACING));
    chk("t3_g1", 32'(gnt), 32'h2);
    chk("t3_d1", 32'(tx_data), 32'hA1);
    wait_trig("t3_2", n);
    chk("t3_sp2", 32'(n), 32'(SPACING));
    chk("t3_g2", 32'(gnt), 32'h4);
    chk("t3_d2", 32'(tx_data), 32'hA2);
    wait_trig("t3_3", n);
    chk("t3_sp3", 32'(n), 32'(SPACING));
    chk("t3_g3", 32'(gnt), 32'h8);
    chk("t3_d3", 32'(tx_data), 32'hA3);
    wait_trig("t3_4", n);
    chk("t3_sp4", 32'(n), 32'(SPACING));
    chk("t3_g4", 32'(gnt), 32'h1);
    chk("t3_d4", 32'(tx_data), 32'hA0);

    // 4: req[1] pulsed for one cycle during WAIT is never granted
    req = 4'h0;
    for (int i = 0; i < 5; i++) step();
    req = 4'b0010;
    step();
    req = 4'h0;
    trig_seen = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (tx_trig) trig_seen++;
    end
    chk("t4_no_trig", 32'(trig_seen), 32'h0);
    chk("t4_idle",    32'(busy),      32'h0);

    // 5: last grant was 0; 0 and 3 rise together, so 3 wins, then 0
    req      = 4'b1001;
    req_data = {8'hC3, 8'h00, 8'h00, 8'hC0};
    step();
    chk("t5_g3", 32'(gnt), 32'h8);
    chk("t5_d3", 32'(tx_data), 32'hC3);
    req = 4'b0001;
    wait_trig("t5_b", n);
    chk("t5_sp", 32'(n), 32'(SPACING));
    chk("t5_g0", 32'(gnt), 32'h1);
    chk("t5_d0", 32'(tx_data), 32'hC0);

    // 6: reset at WAIT count 20 with req[1] high aborts to IDLE
    req      = 4'b0010;
    req_data = {8'h00, 8'h00, 8'h5A, 8'h00};
    for (int i = 0; i < 22; i++) step();
    chk("t6_busy_pre", 32'(busy), 32'h1);
    s_rst = 1'b1;
    step();
    chk("t6_busy", 32'(busy),    32'h0);
    chk("t6_trig", 32'(tx_trig), 32'h0);
    chk("t6_gnt",  32'(gnt),     32'h0);
    chk("t6_data", 32'(tx_data), 32'h00);
    s_rst = 1'b0;
    wait_trig("t6_b", n);
    chk("t6_lat",  32'(n),       32'd1);
    chk("t6_g1",   32'(gnt),     32'h2);
    chk("t6_d1",   32'(tx_data), 32'h5A);
    req = 4'h0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
